usi_uart_rx: RTL and testbench

- Receive path of the USI UART: deserialises the `rxd` line (the USI0 SCLK pin in UART mode) into parallel bytes for the USI register/FIFO logic.
- Oversamples 16x from an internal baud tick, majority-votes each bit, checks parity and stop bits.
- Presents each byte through a 1-deep holding register with a valid/ready handshake.
- Sits directly downstream of the pad-level rxd pin and upstream of the USI RX FIFO.

---
 rtl/usi_uart_pkg.sv | 7 +
 rtl/usi_uart_rx_if.sv | 10 +
 rtl/usi_uart_baud_gen.sv | 15 +
 rtl/usi_uart_rx.sv | 112 +++++++++++
 tb/tb_usi_uart_rx.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/usi_uart_pkg.sv
// usi_uart_pkg: shared FSM states, oversampling constants and data_bits encodings for the USI UART receiver
package usi_uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int OSR = 16;
  localparam logic [3:0] SMP_LO = 4'd7, SMP_MID = 4'd8, SMP_HI = 4'd9, OS_LAST = 4'(OSR - 1);
  localparam logic [1:0] DB5 = 2'd0, DB6 = 2'd1, DB7 = 2'd2, DB8 = 2'd3;
endpackage

// File: rtl/usi_uart_rx_if.sv
// usi_uart_rx_if: received-byte holding register handshake (rx_data, rx_valid, rx_ready, parity_err, frame_err); master = receiver, slave = consumer
interface usi_uart_rx_if;
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic parity_err;
  logic frame_err;
  modport master(output rx_data, rx_valid, parity_err, frame_err, input rx_ready);
  modport slave(input rx_data, rx_valid, parity_err, frame_err, output rx_ready);
endinterface

// File: rtl/usi_uart_baud_gen.sv
// usi_uart_baud_gen: oversample tick every div+1 pclk while en; ports pclk, rst, en, div in, tick out
module usi_uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;
  assign tick = en && cnt == div;
  always_ff @(posedge pclk)
    cnt <= (rst || !en || tick) ? '0 : cnt + DIV_W'(1);
endmodule

// File: rtl/usi_uart_rx.sv
// usi_uart_rx: 16x oversampled UART receiver; ports pclk, rst, rxd, baud_div, frame config, rx_en, rx handshake if, break_det, overrun, busy
module usi_uart_rx
  import usi_uart_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             rxd,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       data_bits,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             stop2,
  input  logic             rx_en,
  usi_uart_rx_if.master    rx,
  output logic             break_det,
  output logic             overrun,
  output logic             busy
);
  logic [SYNC_STAGES-1:0] sync;
  logic rxs, tick, s7, s8, maj, last;
  logic [3:0] os;
  logic [2:0] bcnt;
  logic [7:0] sh;
  logic [1:0] c_db;
  logic c_pen, c_odd, c_st2, px, perr, ferr, zero, brk_s, st_sec, done;
  state_t state, state_n;
  usi_uart_baud_gen #(.DIV_W(DIV_W)) u_baud (.pclk(pclk), .rst(rst), .en(rx_en), .div(baud_div), .tick(tick));
  always_ff @(posedge pclk)
    sync <= rst ? '1 : {sync[SYNC_STAGES-2:0], rxd};
  assign rxs  = sync[SYNC_STAGES-1];
  assign maj  = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
  assign last = bcnt == {1'b0, c_db} + 3'd4;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    if (tick)
      case (state)
        IDLE:    state_n = rxs ? IDLE : START;
        START:   state_n = (os == SMP_HI && maj) ? IDLE : (os == OS_LAST) ? DATA : START;
        DATA:    state_n = (os == OS_LAST && last) ? (c_pen ? PARITY : STOP) : DATA;
        PARITY:  state_n = (os == OS_LAST) ? STOP : PARITY;
        STOP:    state_n = (os == SMP_HI && (st_sec || !c_st2)) ? IDLE : STOP;
        default: state_n = IDLE;
      endcase
  end
  // Per-frame state; config is re-latched on every idle tick so the value at the start edge sticks.
  always_ff @(posedge pclk)
    if (rst || !rx_en) begin
      state <= IDLE;
      os    <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= tick && state == STOP && state_n == IDLE;
      if (tick) begin
        os <= (state == IDLE) ? '0 : os + 4'd1;
        if (os == SMP_LO) s7 <= rxs;
        if (os == SMP_MID) s8 <= rxs;
        if (state == IDLE) begin
          c_db   <= data_bits;
          c_pen  <= parity_en;
          c_odd  <= parity_odd;
          c_st2  <= stop2;
          bcnt   <= '0;
          px     <= 1'b0;
          perr   <= 1'b0;
          ferr   <= 1'b0;
          zero   <= 1'b1;
          st_sec <= 1'b0;
        end
        if (os == SMP_HI) begin
          if (state == DATA) begin
            sh   <= {maj, sh[7:1]};
            px   <= px ^ maj;
            zero <= zero & !maj;
          end
          if (state == PARITY) begin
            perr <= (px ^ maj) != c_odd;
            zero <= zero & !maj;
          end
          if (state == STOP) begin
            ferr   <= ferr | !maj;
            st_sec <= 1'b1;
            if (!st_sec) brk_s <= zero & !maj;
          end
        end
        if (os == OS_LAST && state == DATA) bcnt <= bcnt + 3'd1;
      end
    end
  // Bits arrive at the top of sh; shifting right by 8-n drops stale low bits and zero-fills the top.
  always_ff @(posedge pclk)
    if (rst) begin
      rx.rx_data    <= '0;
      rx.rx_valid   <= 1'b0;
      rx.parity_err <= 1'b0;
      rx.frame_err  <= 1'b0;
      break_det     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      break_det <= done && brk_s;
      overrun   <= done && rx.rx_valid && !rx.rx_ready;
      if (done && (!rx.rx_valid || rx.rx_ready)) begin
        rx.rx_data    <= sh >> (2'd3 - c_db);
        rx.parity_err <= perr;
        rx.frame_err  <= ferr;
        rx.rx_valid   <= 1'b1;
      end else if (rx.rx_ready) rx.rx_valid <= 1'b0;
    end
endmodule

// File: tb/tb_usi_uart_rx.sv
// tb_usi_uart_rx: directed frame stimulus with hand-computed expectations for usi_uart_rx
module tb_usi_uart_rx;
  import usi_uart_pkg::*;
  logic pclk = 1'b0, rst = 1'b1, rxd = 1'b1, rx_en = 1'b1;
  logic [15:0] baud_div = 16'd3;
  logic [1:0] data_bits = DB8;
  logic parity_en = 1'b0, parity_odd = 1'b0, stop2 = 1'b0;
  logic break_det, overrun, busy;
  int n_asrt = 0, n_fail = 0;
  int vld_cyc = 0, brk_cyc = 0, ovr_cyc = 0;
  int v0, b0, o0;
  logic [7:0] cap_data = '0;
  logic cap_pe = 1'b0, cap_fe = 1'b0;
  usi_uart_rx_if rx_if();
  usi_uart_rx #(.DIV_W(16), .SYNC_STAGES(2)) dut (
    .pclk(pclk), .rst(rst), .rxd(rxd), .baud_div(baud_div), .data_bits(data_bits),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2), .rx_en(rx_en),
    .rx(rx_if), .break_det(break_det), .overrun(overrun), .busy(busy)
  );
  always #5 pclk = ~pclk;
  always @(negedge pclk) begin
    if (rx_if.rx_valid) begin
      vld_cyc  <= vld_cyc + 1;
      cap_data <= rx_if.rx_data;
      cap_pe   <= rx_if.parity_err;
      cap_fe   <= rx_if.frame_err;
    end
    if (break_det) brk_cyc <= brk_cyc + 1;
    if (overrun) ovr_cyc <= ovr_cyc + 1;
  end
  task automatic check(input string tag, input int got, input int exp);
    n_asrt++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  // One bit cell is 64 pclk (16 ticks of 4). With rp set, rx_ready is raised for exactly the
  // cycle after the final stop sample tick, i.e. the load-decision cycle.
  task automatic send_bit(input logic v, input logic rp);
    rxd = v;
    if (rp) begin
      repeat (43) @(negedge pclk);
      rx_if.rx_ready = 1'b1;
      @(negedge pclk);
      rx_if.rx_ready = 1'b0;
      repeat (20) @(negedge pclk);
    end else repeat (64) @(negedge pclk);
  endtask
  task automatic send(input logic [7:0] d, input int n, input logic pen, input logic pb,
                      input logic s1, input logic s2, input logic rp);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < n; i++) send_bit(d[i], 1'b0);
    if (pen) send_bit(pb, 1'b0);
    send_bit(s1, rp && !s2);
    if (s2) send_bit(1'b1, rp);
    rxd = 1'b1;
    repeat (128) @(negedge pclk);
  endtask
  initial begin
    rx_if.rx_ready = 1'b1;
    repeat (4) @(negedge pclk);
    check("rst_valid", int'(rx_if.rx_valid), 0);
    check("rst_data", int'(rx_if.rx_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_flags", int'({rx_if.parity_err, rx_if.frame_err, break_det, overrun}), 0);
    rst = 1'b0;
    @(negedge pclk);
    v0 = vld_cyc;
    send(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("8n1_vld_cycles", vld_cyc - v0, 1);
    check("8n1_data", int'(cap_data), 'h55);
    check("8n1_errs", int'({cap_pe, cap_fe}), 0);
    check("8n1_valid_clr", int'(rx_if.rx_valid), 0);
    data_bits = DB7; parity_en = 1'b1; parity_odd = 1'b0;
    send(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("7e1_bad_data", int'(cap_data), 'h41);
    check("7e1_bad_pe", int'(cap_pe), 1);
    send(8'h41, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("7e1_ok_pe", int'(cap_pe), 0);
    check("7e1_ok_fe", int'(cap_fe), 0);
    data_bits = DB5; parity_odd = 1'b1; stop2 = 1'b1;
    v0 = vld_cyc;
    send(8'h1F, 5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("5o2_vld", vld_cyc - v0, 1);
    check("5o2_data", int'(cap_data), 'h1F);
    check("5o2_errs", int'({cap_pe, cap_fe}), 0);
    data_bits = DB8; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    b0 = brk_cyc;
    send(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ferr_data", int'(cap_data), 'hA5);
    check("ferr_fe", int'(cap_fe), 1);
    check("ferr_nobrk", brk_cyc - b0, 0);
    send(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("brk_data", int'(cap_data), 0);
    check("brk_fe", int'(cap_fe), 1);
    check("brk_pulse", brk_cyc - b0, 1);
    v0 = vld_cyc;
    rxd = 1'b0;
    repeat (24) @(negedge pclk);
    check("glitch_busy", int'(busy), 1);
    rxd = 1'b1;
    repeat (104) @(negedge pclk);
    check("glitch_idle", int'(busy), 0);
    check("glitch_novld", vld_cyc - v0, 0);
    rx_if.rx_ready = 1'b0;
    o0 = ovr_cyc;
    send(8'h12, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("ovr_first", int'(rx_if.rx_data), 'h12);
    send(8'h34, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("ovr_keep", int'(rx_if.rx_data), 'h12);
    check("ovr_valid", int'(rx_if.rx_valid), 1);
    check("ovr_pulse", ovr_cyc - o0, 1);
    send(8'h56, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("ovr_swap_data", int'(rx_if.rx_data), 'h56);
    check("ovr_swap_valid", int'(rx_if.rx_valid), 1);
    check("ovr_swap_noovr", ovr_cyc - o0, 1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("mid_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge pclk);
    check("mid_rst_valid", int'(rx_if.rx_valid), 0);
    check("mid_rst_data", int'(rx_if.rx_data), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_flags", int'({rx_if.parity_err, rx_if.frame_err, break_det, overrun}), 0);
    rst = 1'b0;
    rxd = 1'b1;
    rx_if.rx_ready = 1'b1;
    v0 = vld_cyc;
    repeat (129) @(negedge pclk);
    check("mid_rst_novld", vld_cyc - v0, 0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    rx_en = 1'b0;
    @(negedge pclk);
    check("dis_idle", int'(busy), 0);
    rxd = 1'b1;
    repeat (400) @(negedge pclk);
    rx_en = 1'b1;
    repeat (129) @(negedge pclk);
    check("dis_novld", vld_cyc - v0, 0);
    send(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("c3_vld", vld_cyc - v0, 1);
    check("c3_data", int'(cap_data), 'hC3);
    check("c3_errs", int'({cap_pe, cap_fe}), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
